shift_add_multiplier: RTL

- Parametrised sequential multiplier: WIDTH-bit multiplicand S times WIDTH-bit multiplier B, producing a 2*WIDTH-bit product in A:B plus a sign/carry bit X.
- Supports signed (two's-complement, subtract on the final step) and unsigned modes.
- Integrates the X bit, the A/B shift registers, the (WIDTH+1)-bit add/subtract path and the control FSM in one block.
- Driven by synchronized, active-high button levels from the board top level.

---
 rtl/shift_add_multiplier_if.sv | 29 ++
 rtl/shift_add_multiplier.sv | 126 ++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier_if.sv
// Purpose : operand/control/result bundle between board logic and shift_add_multiplier.
// Latency : wiring only, no storage.
// Backpressure: none; Execute is a level request and Busy/Done report progress.
// Ports   : master drives Execute, ClearXA_LoadB, Signed_Mode, Din;
//           slave drives X, Aval, Bval, Product, Busy, Done.
interface shift_add_multiplier_if #(
   parameter int WIDTH = 8
);
   logic               Execute;
   logic               ClearXA_LoadB;
   logic               Signed_Mode;
   logic [WIDTH-1:0]   Din;
   logic               X;
   logic [WIDTH-1:0]   Aval;
   logic [WIDTH-1:0]   Bval;
   logic [2*WIDTH-1:0] Product;
   logic               Busy;
   logic               Done;

   modport master (
      output Execute, ClearXA_LoadB, Signed_Mode, Din,
      input  X, Aval, Bval, Product, Busy, Done
   );

   modport slave (
      input  Execute, ClearXA_LoadB, Signed_Mode, Din,
      output X, Aval, Bval, Product, Busy, Done
   );
endinterface

// File: rtl/shift_add_multiplier.sv
// Purpose : sequential shift-add multiplier, S (WIDTH) x B (WIDTH) -> {X,A,B}, signed or unsigned.
// Latency : 2*WIDTH cycles of Busy after the start edge, then Done held until Execute drops.
// Backpressure: inputs other than Reset are ignored while Busy or Done; one run per Execute level.
// Ports   : Clk, Reset (sync, active-high); bus (slave modport) carries the request inputs
//           Execute/ClearXA_LoadB/Signed_Mode/Din and the registered results X/Aval/Bval/Product/Busy/Done.
module shift_add_multiplier #(
   parameter int WIDTH = 8
) (
   input logic                   Clk,
   input logic                   Reset,
   shift_add_multiplier_if.slave bus
);
   localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ADD, SHIFT, HOLD} state_t;

   state_t           state_q, state_d;
   logic             x_q, x_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             mode_q, mode_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             last_step;
   logic             sub;
   logic [WIDTH:0]   ext_a, ext_s, addend, sum;

   assign last_step = (cnt_q == LAST);

   // (WIDTH+1)-bit add path; the final step of a signed run subtracts because
   // the multiplier's MSB carries negative weight.
   always_comb begin
      ext_a  = {mode_q & a_q[WIDTH-1], a_q};
      ext_s  = {mode_q & s_q[WIDTH-1], s_q};
      sub    = mode_q & last_step;
      addend = sub ? ~ext_s : ext_s;
      sum    = ext_a + addend + {{WIDTH{1'b0}}, sub};
   end

   // State register plus datapath registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         x_q     <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.Execute) state_d = ADD;
         ADD:     state_d = SHIFT;
         SHIFT:   state_d = last_step ? HOLD : ADD;
         HOLD:    if (!bus.Execute) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values.
   always_comb begin
      x_d    = x_q;
      a_d    = a_q;
      b_d    = b_q;
      s_d    = s_q;
      mode_d = mode_q;
      cnt_d  = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.Execute) begin
               // B is kept so a re-run multiplies against the previous low half.
               s_d    = bus.Din;
               mode_d = bus.Signed_Mode;
               a_d    = '0;
               x_d    = 1'b0;
               cnt_d  = '0;
            end else if (bus.ClearXA_LoadB) begin
               x_d = 1'b0;
               a_d = '0;
               b_d = bus.Din;
            end
         end
         ADD: begin
            if (b_q[0]) begin
               a_d = sum[WIDTH-1:0];
               x_d = sum[WIDTH];
            end
         end
         SHIFT: begin
            a_d = {x_q, a_q[WIDTH-1:1]};
            b_d = {a_q[0], b_q[WIDTH-1:1]};
            // Signed: X is the sign and stays replicated. Unsigned: X is a carry
            // that is consumed by this shift, so it must not be shifted in twice.
            x_d = mode_q ? x_q : 1'b0;
            if (!last_step) cnt_d = cnt_q + CW'(1);
         end
         default: ;
      endcase
   end

   // Output decode from registered state only.
   always_comb begin
      bus.Busy = (state_q == ADD) || (state_q == SHIFT);
      bus.Done = (state_q == HOLD);
   end

   assign bus.X       = x_q;
   assign bus.Aval    = a_q;
   assign bus.Bval    = b_q;
   assign bus.Product = {a_q, b_q};
endmodule
